// File: rtl/dsp_mult_share_arbiter.sv
// Round-robin share of one signed NxN multiplier among NREQ requesters.
// Products leave a PIPE-deep register pipeline tagged with the requester index.
module dsp_mult_share_arbiter #(
  parameter  int unsigned N    = 4,
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned PIPE = 2,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_x,
  input  logic [NREQ*N-1:0]   req_y,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IW-1:0]       rsp_id,
  output logic [2*N-1:0]      rsp_r
);

  logic                  w_advance;
  logic                  w_found;
  logic                  w_transfer;
  logic [IW-1:0]         w_gnt_idx;
  logic [N-1:0]          w_gnt_x;
  logic [N-1:0]          w_gnt_y;
  logic signed [2*N-1:0] w_xs;
  logic signed [2*N-1:0] w_ys;
  logic signed [2*N-1:0] w_prod;

  logic [IW-1:0]         r_ptr;
  logic [PIPE-1:0]       r_vld;
  logic [IW-1:0]         r_id [PIPE];
  logic [N-1:0]          r_x;
  logic [N-1:0]          r_y;

  // A full output register that is not being taken freezes every stage.
  assign w_advance  = !(rsp_valid && !rsp_ready);
  assign w_transfer = w_advance && w_found;

  // Search starts just after the last winner, so requester ptr+1 has top priority.
  always_comb begin : p_grant
    logic [IW-1:0] sel;
    sel       = '0;
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      sel = IW'((32'(r_ptr) + k) % NREQ);
      if (!w_found && req_valid[sel]) begin
        w_found   = 1'b1;
        w_gnt_idx = sel;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_transfer) req_ready[w_gnt_idx] = 1'b1;
  end

  always_comb begin
    w_gnt_x = '0;
    w_gnt_y = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IW'(i) == w_gnt_idx) begin
        w_gnt_x = req_x[i*N +: N];
        w_gnt_y = req_y[i*N +: N];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= IW'(NREQ - 1);
    end else if (w_transfer) begin
      r_ptr <= w_gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_x   <= '0;
      r_y   <= '0;
      for (int s = 0; s < int'(PIPE); s++) r_id[s] <= '0;
    end else if (w_advance) begin
      r_vld[0] <= w_transfer;
      r_id[0]  <= w_gnt_idx;
      r_x      <= w_gnt_x;
      r_y      <= w_gnt_y;
      for (int s = 1; s < int'(PIPE); s++) begin
        r_vld[s] <= r_vld[s-1];
        r_id[s]  <= r_id[s-1];
      end
    end
  end

  // Sign-extend to 2N so the truncated 2N product is exact.
  assign w_xs   = {{N{r_x[N-1]}}, r_x};
  assign w_ys   = {{N{r_y[N-1]}}, r_y};
  assign w_prod = w_xs * w_ys;

  generate
    if (PIPE == 1) begin : g_pipe1
      assign rsp_r = w_prod;
    end else begin : g_pipen
      logic [2*N-1:0] r_prod [PIPE-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < int'(PIPE) - 1; s++) r_prod[s] <= '0;
        end else if (w_advance) begin
          r_prod[0] <= w_prod;
          for (int s = 1; s < int'(PIPE) - 1; s++) r_prod[s] <= r_prod[s-1];
        end
      end

      assign rsp_r = r_prod[PIPE-2];
    end
  endgenerate

  assign rsp_valid = r_vld[PIPE-1];
  assign rsp_id    = r_id[PIPE-1];

endmodule

// File: tb/tb_dsp_mult_share_arbiter.sv
// Directed and random bench for dsp_mult_share_arbiter with an in-order scoreboard.
module tb_dsp_mult_share_arbiter;

  localparam int unsigned N    = 4;
  localparam int unsigned NREQ = 4;
  localparam int unsigned PIPE = 2;
  localparam int unsigned IW   = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_x;
  logic [NREQ*N-1:0] req_y;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [2*N-1:0]    rsp_r;

  dsp_mult_share_arbiter #(.N(N), .NREQ(NREQ), .PIPE(PIPE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_r     (rsp_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0]  id;
    logic [2*N-1:0] r;
    int             c;
  } exp_t;

  exp_t            sb[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  int              cyc     = 0;
  int              n_acc   = 0;
  bit              chk_lat = 1'b0;
  bit              stall_prev = 1'b0;
  logic [IW-1:0]   held_id;
  logic [2*N-1:0]  held_r;
  logic [NREQ-1:0] acc_mask;

  function automatic logic [2*N-1:0] model_prod(input logic [N-1:0] x, input logic [N-1:0] y);
    int xi, yi, p;
    xi = int'($signed(x));
    yi = int'($signed(y));
    p  = xi * yi;
    return p[2*N-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    exp_t e;
    logic [NREQ-1:0] acc;
    acc = req_valid & req_ready;
    if (stall_prev) begin
      chk("rsp_hold_valid", 32'(rsp_valid), 1);
      chk("rsp_hold_id", 32'(rsp_id), 32'(held_id));
      chk("rsp_hold_r", 32'(rsp_r), 32'(held_r));
    end
    if (rsp_valid && rsp_ready) begin
      chk("rsp_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_r", 32'(rsp_r), 32'(e.r));
        if (chk_lat) chk("rsp_latency", cyc - e.c, PIPE);
      end
    end
    chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
    if (rsp_valid && !rsp_ready) chk("ready_stall", 32'(req_ready), 0);
    for (int i = 0; i < int'(NREQ); i++) begin
      if (acc[i]) begin
        e.id = IW'(i);
        e.r  = model_prod(req_x[i*N +: N], req_y[i*N +: N]);
        e.c  = cyc;
        sb.push_back(e);
        n_acc++;
      end
    end
    acc_mask   = acc;
    stall_prev = rsp_valid && !rsp_ready;
    held_id    = rsp_id;
    held_r     = rsp_r;
  endtask

  // Inputs are set at the falling edge; sampling happens 2 time units later.
  task automatic step();
    #2;
    observe();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) step();
    chk("drain_empty", sb.size(), 0);
    repeat (3) step();
  endtask

  initial begin
    logic [NREQ-1:0] exp_gnt;
    int target;
    rst_n     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b1;
    acc_mask  = '0;
    held_id   = '0;
    held_r    = '0;
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_id", 32'(rsp_id), 0);
    chk("reset_rsp_r", 32'(rsp_r), 0);
    rst_n = 1'b1;

    // T2: all requesters valid from reset; grants rotate 0,1,2,3,...
    chk_lat   = 1'b1;
    req_x     = {4'h8, 4'hD, 4'h7, 4'h3};
    req_y     = {4'h7, 4'hC, 4'h8, 4'h5};
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      exp_gnt = '0;
      exp_gnt[k % NREQ] = 1'b1;
      #1;
      chk("t2_grant", 32'(req_ready), 32'(exp_gnt));
      step();
    end
    drain();

    // T1: single op from requester 2, -8 * -8.
    req_x     = '0;
    req_y     = '0;
    req_x[2*N +: N] = 4'h8;
    req_y[2*N +: N] = 4'h8;
    req_valid = 4'b0100;
    step();
    chk("t1_accepted", 32'(acc_mask), 32'(4'b0100));
    drain();

    // T6: only requester 3 valid; granted every cycle.
    req_valid = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      req_x[3*N +: N] = N'($urandom);
      req_y[3*N +: N] = N'($urandom);
      #1;
      chk("t6_grant", 32'(req_ready), 32'(4'b1000));
      step();
    end
    drain();

    // T3: fill the pipe, stall five cycles, then release.
    chk_lat   = 1'b0;
    req_x     = {4'h9, 4'h6, 4'hF, 4'h2};
    req_y     = {4'h3, 4'hA, 4'h8, 4'h7};
    req_valid = '1;
    repeat (4) step();
    rsp_ready = 1'b0;
    repeat (5) step();
    req_valid = '0;
    rsp_ready = 1'b1;
    chk("t3_inflight", sb.size(), PIPE);
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      #1;
      chk("t3_back_to_back", 32'(rsp_valid), 1);
      step();
    end
    drain();

    // T4: random traffic and random backpressure.
    target = n_acc + 1000;
    req_valid = '0;
    for (int c = 0; c < 20000 && n_acc < target; c++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      step();
      for (int i = 0; i < int'(NREQ); i++) begin
        if (acc_mask[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i]     = 1'b1;
          req_x[i*N +: N]  = N'($urandom);
          req_y[i*N +: N]  = N'($urandom);
        end
      end
    end
    chk("t4_op_count", 32'(n_acc >= target), 1);
    drain();

    // T5: reset with two products in flight.
    req_x     = {4'h1, 4'h2, 4'h5, 4'h3};
    req_y     = {4'h4, 4'h3, 4'h6, 4'h7};
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    chk("t5_busy", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(rsp_valid), 0);
    chk("t5_async_id", 32'(rsp_id), 0);
    chk("t5_async_r", 32'(rsp_r), 0);
    sb.delete();
    stall_prev = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0110;
    #1;
    chk("t5_first_grant", 32'(req_ready), 32'(4'b0010));
    step();
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
